// File: rtl/mul_hilo_sequencer_pkg.sv
// ALU control codes and multiply-sequencer state encoding shared by the
// multiply sequencer and its surroundings.
package alu_ctrl_pkg;

    localparam logic [4:0] OP_MULT  = 5'b00011;
    localparam logic [4:0] OP_MULTU = 5'b00100;
    localparam logic [4:0] OP_MUL   = 5'b10011;
    localparam logic [4:0] OP_MADD  = 5'b10100;
    localparam logic [4:0] OP_MSUB  = 5'b10101;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        FINISH
    } state_t;

    function automatic logic is_mul_op(input logic [4:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB};
    endfunction

endpackage

// File: rtl/mul_hilo_sequencer_if.sv
// Pipeline-facing bus of the multiply sequencer: launch, HI/LO writes,
// stall/completion and architectural HI/LO.
interface mul_hilo_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [4:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             HiWe;
    logic             LoWe;
    logic [WIDTH-1:0] WrData;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, A, B, HiWe, LoWe, WrData,
        input  Busy, Done, Result, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B, HiWe, LoWe, WrData,
        output Busy, Done, Result, Hi, Lo
    );
endinterface

// File: rtl/mul_hilo_sequencer_radix_step.sv
// One shift-add iteration: folds the low RADIX_BITS multiplier bits into the
// accumulator, then advances multiplicand and multiplier by RADIX_BITS.
module mul_radix_step #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0]   i_mplr,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [2*WIDTH-1:0] o_mcand,
    output logic [WIDTH-1:0]   o_mplr
);

    logic [2*WIDTH-1:0] w_sum;

    always_comb begin
        // NOTE: w_sum gets its default first so every path assigns it (no latch);
        // blocking '=' is correct here because each partial product builds on the last.
        w_sum = i_acc;
        for (int j = 0; j < RADIX_BITS; j++) begin
            if (i_mplr[j]) w_sum = w_sum + (i_mcand << j);
        end
    end

    assign o_acc   = w_sum;
    assign o_mcand = i_mcand << RADIX_BITS;
    assign o_mplr  = i_mplr >> RADIX_BITS;

endmodule

// File: rtl/mul_hilo_sequencer.sv
// Iterative shift-add multiply sequencer owning HI/LO (MULT/MULTU/MUL/MADD/MSUB).
// Define MUL_EARLY_TERM_EN to leave ITER once the remaining multiplier is zero.
module mul_hilo_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2
) (
    input logic                Clk,
    input logic                Rst,
    mul_hilo_sequencer_if.slave bus
);

    localparam int N     = WIDTH / RADIX_BITS;
    localparam int CNT_W = $clog2(N) + 1;

    state_t             r_state;
    logic [4:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_mplr;
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic               r_neg, r_busy, r_done;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result, r_hi, r_lo;

    logic               w_signed, w_last;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_step_mplr;
    logic [2*WIDTH-1:0] w_step_acc, w_step_mcand, w_prod, w_hilo;

    assign w_signed = (r_op != OP_MULTU);
    assign w_mag_a  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_mag_b  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;
    assign w_prod   = r_neg ? -w_step_acc : w_step_acc;
    assign w_hilo   = {r_hi, r_lo};

`ifdef MUL_EARLY_TERM_EN
    assign w_last = (r_cnt == CNT_W'(N - 1)) || (w_step_mplr == '0);
`else
    assign w_last = (r_cnt == CNT_W'(N - 1));
`endif

    mul_radix_step #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_mplr  (r_mplr),
        .o_acc   (w_step_acc),
        .o_mcand (w_step_mcand),
        .o_mplr  (w_step_mplr)
    );

    // NOTE: sequential state uses non-blocking '<=' only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_mplr   <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.HiWe) r_hi <= bus.WrData;
                    if (bus.LoWe) r_lo <= bus.WrData;
                    if (bus.Start && is_mul_op(bus.Op)) begin
                        r_op    <= bus.Op;
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
                    r_mplr  <= w_mag_b;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_neg   <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_state <= ITER;
                end
                ITER: begin
                    r_acc   <= w_step_acc;
                    r_mcand <= w_step_mcand;
                    r_mplr  <= w_step_mplr;
                    r_cnt   <= r_cnt + 1'b1;
                    // Final sign fix-up and HI/LO commit land on the edge into FINISH
                    if (w_last) begin
                        case (r_op)
                            OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_prod;
                            OP_MADD:           {r_hi, r_lo} <= w_hilo + w_prod;
                            OP_MSUB:           {r_hi, r_lo} <= w_hilo - w_prod;
                            OP_MUL:            r_result     <= w_prod[WIDTH-1:0];
                            default: ;
                        endcase
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Busy   = r_busy;
    assign bus.Done   = r_done;
    assign bus.Result = r_result;
    assign bus.Hi     = r_hi;
    assign bus.Lo     = r_lo;

endmodule

// File: tb/tb_mul_hilo_sequencer.sv
// Self-checking bench for mul_hilo_sequencer: directed cases plus randomized
// operations compared against a 64-bit arithmetic model of HI/LO and Result.
module tb_mul_hilo_sequencer;
    import alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_hilo_sequencer_if #(.WIDTH(32)) bus ();

    mul_hilo_sequencer #(
        .WIDTH      (32),
        .RADIX_BITS (2)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] m_hilo;
    logic [31:0] m_result;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (op == OP_MULTU) return {32'h0, a} * {32'h0, b};
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Cycle (counting the Start edge as edge 0) in which Done is expected
    function automatic int exp_lat(input logic [4:0] op, input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        logic [31:0] m;
        int          bits;
        m    = (op != OP_MULTU && b[31]) ? -b : b;
        bits = 0;
        for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
        return 2 + ((bits <= 2) ? 1 : (bits + 1) / 2);
`else
        return 18;
`endif
    endfunction

    task automatic idle_inputs();
        bus.Start  = 1'b0;
        bus.HiWe   = 1'b0;
        bus.LoWe   = 1'b0;
    endtask

    task automatic write_hilo(input string tag, input logic hiwe, input logic lowe,
                              input logic [31:0] wd);
        bus.HiWe   = hiwe;
        bus.LoWe   = lowe;
        bus.WrData = wd;
        if (hiwe) m_hilo[63:32] = wd;
        if (lowe) m_hilo[31:0]  = wd;
        @(posedge clk); #1;
        idle_inputs();
        check({tag, "/hi"}, {32'h0, bus.Hi}, {32'h0, m_hilo[63:32]});
        check({tag, "/lo"}, {32'h0, bus.Lo}, {32'h0, m_hilo[31:0]});
    endtask

    // Launch one op (optionally with a same-cycle HI/LO write); at cycle 'inject'
    // throw a stray Start plus HI/LO write at the busy unit, which must be ignored.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic hiwe, input logic lowe,
                         input logic [31:0] wd, input int inject);
        int          c, lat;
        logic [63:0] p;
        if (hiwe) m_hilo[63:32] = wd;
        if (lowe) m_hilo[31:0]  = wd;
        p = ref_prod(op, a, b);
        case (op)
            OP_MULT, OP_MULTU: m_hilo = p;
            OP_MADD:           m_hilo = m_hilo + p;
            OP_MSUB:           m_hilo = m_hilo - p;
            OP_MUL:            m_result = p[31:0];
            default: ;
        endcase
        lat = exp_lat(op, b);

        bus.Start  = 1'b1;
        bus.Op     = op;
        bus.A      = a;
        bus.B      = b;
        bus.HiWe   = hiwe;
        bus.LoWe   = lowe;
        bus.WrData = wd;
        @(posedge clk); #1;
        idle_inputs();
        check({tag, "/busy_c1"}, {63'h0, bus.Busy}, 64'h1);

        c = 1;
        while (bus.Done !== 1'b1 && c < 60) begin
            if (c == inject) begin
                bus.Start  = 1'b1;
                bus.Op     = OP_MULTU;
                bus.A      = 32'd5;
                bus.B      = 32'd5;
                bus.HiWe   = 1'b1;
                bus.LoWe   = 1'b1;
                bus.WrData = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            idle_inputs();
            c++;
        end
        check({tag, "/done_cycle"}, 64'(c), 64'(lat));
        check({tag, "/busy_done"}, {63'h0, bus.Busy}, 64'h1);
        check({tag, "/hi"}, {32'h0, bus.Hi}, {32'h0, m_hilo[63:32]});
        check({tag, "/lo"}, {32'h0, bus.Lo}, {32'h0, m_hilo[31:0]});
        if (op == OP_MUL) check({tag, "/result"}, {32'h0, bus.Result}, {32'h0, m_result});

        @(posedge clk); #1;
        check({tag, "/done_pulse"}, {63'h0, bus.Done}, 64'h0);
        check({tag, "/busy_after"}, {63'h0, bus.Busy}, 64'h0);
    endtask

    initial begin
        logic [4:0]  ops [5];
        logic        saw_done;
        ops = '{OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB};

        rst = 1'b1;
        idle_inputs();
        bus.Op = '0; bus.A = '0; bus.B = '0; bus.WrData = '0;
        m_hilo = '0;
        m_result = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/busy",   {63'h0, bus.Busy},   64'h0);
        check("reset/done",   {63'h0, bus.Done},   64'h0);
        check("reset/result", {32'h0, bus.Result}, 64'h0);
        check("reset/hi",     {32'h0, bus.Hi},     64'h0);
        check("reset/lo",     {32'h0, bus.Lo},     64'h0);
        rst = 1'b0;

        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 0);
        check("multu_max/hi_const", {32'h0, bus.Hi}, 64'hFFFF_FFFE);
        do_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 32'h0, 0);
        check("mult_neg/lo_const", {32'h0, bus.Lo}, 64'hFFFF_FFEB);

        write_hilo("clr_hi", 1'b1, 1'b0, 32'h0);
        write_hilo("wr_lo", 1'b0, 1'b1, 32'hFFFF_FFFF);
        do_op("madd_carry", OP_MADD, 32'd1, 32'd1, 1'b0, 1'b0, 32'h0, 0);
        check("madd_carry/hi_const", {32'h0, bus.Hi}, 64'h1);

        write_hilo("clr_both", 1'b1, 1'b1, 32'h0);
        do_op("msub", OP_MSUB, 32'd2, 32'd3, 1'b0, 1'b0, 32'h0, 0);
        check("msub/lo_const", {32'h0, bus.Lo}, 64'hFFFF_FFFA);
        do_op("mul", OP_MUL, 32'd6, 32'd7, 1'b0, 1'b0, 32'h0, 0);
        check("mul/result_const", {32'h0, bus.Result}, 64'd42);

        do_op("multu_small", OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b0, 32'h0, 0);
        do_op("mult_b_zero", OP_MULT, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        do_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 0);
        do_op("madd_same_wr", OP_MADD, 32'hFFFF_FFFE, 32'd9, 1'b1, 1'b1, 32'h0000_0100, 0);
        do_op("mult_stray_start", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 32'h0, 3);

        // Unsupported opcode is dropped: no Busy, no Done, HI/LO untouched
        bus.Start = 1'b1;
        bus.Op    = 5'b00000;
        bus.A     = 32'd9;
        bus.B     = 32'd9;
        @(posedge clk); #1;
        idle_inputs();
        check("bad_op/busy", {63'h0, bus.Busy}, 64'h0);
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) saw_done = 1'b1;
        end
        check("bad_op/quiet", {63'h0, saw_done}, 64'h0);
        check("bad_op/lo", {32'h0, bus.Lo}, {32'h0, m_hilo[31:0]});

        for (int i = 0; i < 24; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b, wd;
            logic        hw, lw;
            op = ops[$urandom_range(0, 4)];
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = -b;
            hw = ($urandom_range(0, 3) == 0);
            lw = ($urandom_range(0, 3) == 0);
            wd = $urandom;
            do_op($sformatf("rand%0d", i), op, a, b, hw, lw, wd, ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        // Reset in cycle 5 of a MULTU aborts it and clears HI/LO
        write_hilo("pre_rst", 1'b1, 1'b1, 32'hA5A5_5A5A);
        bus.Start = 1'b1;
        bus.Op    = OP_MULTU;
        bus.A     = 32'd5;
        bus.B     = 32'd5;
        @(posedge clk); #1;
        idle_inputs();
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hilo = '0;
        m_result = '0;
        check("rst_mid/busy",   {63'h0, bus.Busy},   64'h0);
        check("rst_mid/done",   {63'h0, bus.Done},   64'h0);
        check("rst_mid/hi",     {32'h0, bus.Hi},     {32'h0, m_hilo[63:32]});
        check("rst_mid/lo",     {32'h0, bus.Lo},     {32'h0, m_hilo[31:0]});
        check("rst_mid/result", {32'h0, bus.Result}, {32'h0, m_result});

        do_op("post_rst", OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
